seq_1001_tx: RTL and testbench



---
 rtl/seq_1001_tx.sv | 117 +++++++++++
 tb/tb_seq_1001_tx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_1001_tx.sv
// seq_1001_tx: serial stimulus transmitter for an overlapping "1001" Moore
// detector. Parallel words are accepted over valid/ready and shifted out
// MSB-first on Sout. A golden model watches every bit on the line, including
// idle bits, and produces the expected detector output and a match count.
module seq_1001_tx #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CNT_W    = 8,
    parameter logic        IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] din,
    output logic             load_ready,
    output logic             Sout,
    output logic             busy,
    output logic             done,
    output logic             exp_match,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [IDX_W-1:0]   idx_q;
    logic               sout_q;
    logic               done_q;

    logic [2:0]         hist_q;
    logic               match_q;
    logic               match_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    // Golden next-state: match on the last four line bits, saturating count.
    always_comb begin
        match_d = ({hist_q, sout_q} == 4'b1001);
        cnt_d   = cnt_q;
        if (match_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Transmit FSM: the first bit is registered onto Sout at the accepting
    // edge, so shreg_q holds only the bits still to be sent.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            sout_q  <= IDLE_LVL;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    sout_q <= IDLE_LVL;
                    if (load_valid) begin
                        sout_q  <= din[WIDTH-1];
                        shreg_q <= din << 1;
                        idx_q   <= IDX_W'(WIDTH - 1);
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (idx_q == '0) begin
                        sout_q  <= IDLE_LVL;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        sout_q  <= shreg_q[WIDTH-1];
                        shreg_q <= shreg_q << 1;
                        idx_q   <= idx_q - IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    sout_q  <= IDLE_LVL;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    sout_q  <= IDLE_LVL;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Golden detector model: tracks every line bit regardless of FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q  <= 3'b000;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            hist_q  <= {hist_q[1:0], sout_q};
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    assign load_ready = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_SHIFT);
    assign Sout       = sout_q;
    assign done       = done_q;
    assign exp_match  = match_q;
    assign match_cnt  = cnt_q;

endmodule

// File: tb/tb_seq_1001_tx.sv
// Directed bench for seq_1001_tx: one default instance and one with a 2-bit
// counter share the same stimulus. An independent Moore "1001" detector
// watches the line and is compared against exp_match/match_cnt every cycle.
module tb_seq_1001_tx;

    logic       clk;
    logic       reset;
    logic       load_valid;
    logic [7:0] din;

    logic       ready1, sout1, busy1, done1, em1;
    logic [7:0] cnt1;
    logic       ready2, sout2, busy2, done2, em2;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    seq_1001_tx #(.WIDTH(8), .CNT_W(8), .IDLE_LVL(1'b0)) u1 (
        .clk(clk), .reset(reset), .load_valid(load_valid), .din(din),
        .load_ready(ready1), .Sout(sout1), .busy(busy1), .done(done1),
        .exp_match(em1), .match_cnt(cnt1)
    );

    seq_1001_tx #(.WIDTH(8), .CNT_W(2), .IDLE_LVL(1'b0)) u2 (
        .clk(clk), .reset(reset), .load_valid(load_valid), .din(din),
        .load_ready(ready2), .Sout(sout2), .busy(busy2), .done(done2),
        .exp_match(em2), .match_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference Moore detector, state-based, sampling the line at posedge.
    typedef enum logic [2:0] {R0, R1, R10, R100, R1001} ref_t;
    ref_t       ref_q;
    logic [7:0] rc1;
    logic [1:0] rc2;

    function automatic ref_t ref_next(input ref_t s, input logic b);
        case (s)
            R0:      return b ? R1    : R0;
            R1:      return b ? R1    : R10;
            R10:     return b ? R1    : R100;
            R100:    return b ? R1001 : R0;
            default: return b ? R1    : R10;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            ref_q <= R0;
            rc1   <= 8'd0;
            rc2   <= 2'd0;
        end else begin
            ref_q <= ref_next(ref_q, sout1);
            if (ref_next(ref_q, sout1) == R1001) begin
                if (rc1 != 8'hFF) rc1 <= rc1 + 8'd1;
                if (rc2 != 2'd3)  rc2 <= rc2 + 2'd1;
            end
        end
    end

    always @(negedge clk) begin
        chk("mon_em1",  {31'd0, em1},   {31'd0, ref_q == R1001});
        chk("mon_em2",  {31'd0, em2},   {31'd0, ref_q == R1001});
        chk("mon_cnt1", {24'd0, cnt1},  {24'd0, rc1});
        chk("mon_cnt2", {30'd0, cnt2},  {30'd0, rc2});
        chk("mon_sout2", {31'd0, sout2}, {31'd0, sout1});
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept a word, then check each line bit and the expected-match flag
    // per bit position (position 0 is the first bit on Sout). Ends in DONE.
    task automatic run_word(input logic [7:0] w, input logic [7:0] bits, input logic [7:0] em);
        load_valid = 1'b1;
        din        = w;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("word_sout",  {31'd0, sout1},  {31'd0, bits[7-i]});
            chk("word_em",    {31'd0, em1},    {31'd0, em[7-i]});
            chk("word_busy",  {31'd0, busy1},  32'd1);
            chk("word_ready", {31'd0, ready1}, 32'd0);
            chk("word_done",  {31'd0, done1},  32'd0);
            tick();
        end
        chk("done_pulse", {31'd0, done1},  32'd1);
        chk("done_sout",  {31'd0, sout1},  32'd0);
        chk("done_ready", {31'd0, ready1}, 32'd0);
        chk("done_busy",  {31'd0, busy1},  32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        din        = 8'h00;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_ready", {31'd0, ready1}, 32'd1);
        chk("rst_busy",  {31'd0, busy1},  32'd0);
        chk("rst_done",  {31'd0, done1},  32'd0);
        chk("rst_sout",  {31'd0, sout1},  32'd0);
        chk("rst_em",    {31'd0, em1},    32'd0);
        chk("rst_cnt1",  {24'd0, cnt1},   32'd0);
        chk("rst_cnt2",  {30'd0, cnt2},   32'd0);

        // 10010010: matches shown while positions 4 and 7 are on the line
        run_word(8'b10010010, 8'b10010010, 8'b00001001);
        chk("t1_done_em", {31'd0, em1},  32'd0);
        chk("t1_cnt",     {24'd0, cnt1}, 32'd2);
        tick();
        chk("t1_idle_done",  {31'd0, done1},  32'd0);
        chk("t1_idle_ready", {31'd0, ready1}, 32'd1);
        chk("t1_idle_sout",  {31'd0, sout1},  32'd0);

        // 0x09 then 0x80: match at end of word, then 1,0(DONE),0(IDLE),1
        run_word(8'h09, 8'h09, 8'h00);
        chk("t2_done_em", {31'd0, em1},  32'd1);
        chk("t2_cnt_a",   {24'd0, cnt1}, 32'd3);
        tick();
        chk("t2_idle_ready", {31'd0, ready1}, 32'd1);
        chk("t2_idle_em",    {31'd0, em1},    32'd0);
        run_word(8'h80, 8'h80, 8'b01000000);
        chk("t2_cnt_b", {24'd0, cnt1}, 32'd4);
        tick();

        // Hold load_valid with din changing: only 0xA5 is sent
        load_valid = 1'b1;
        din        = 8'hA5;
        tick();
        for (int i = 0; i < 8; i++) begin
            din = 8'h5A ^ 8'(i * 37);
            chk("t3_ready", {31'd0, ready1}, 32'd0);
            chk("t3_sout",  {31'd0, sout1},  {31'd0, ((8'hA5 >> (7 - i)) & 8'h01) != 8'h00});
            chk("t3_em",    {31'd0, em1},    {31'd0, i == 6});
            tick();
        end
        din = 8'h3C;
        chk("t3_done_ready", {31'd0, ready1}, 32'd0);
        chk("t3_done",       {31'd0, done1},  32'd1);
        tick();
        chk("t3_idle_ready", {31'd0, ready1}, 32'd1);
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t3b_busy", {31'd0, busy1}, 32'd1);
            chk("t3b_sout", {31'd0, sout1}, {31'd0, ((8'h3C >> (7 - i)) & 8'h01) != 8'h00});
            tick();
        end
        chk("t3b_done", {31'd0, done1}, 32'd1);
        chk("t3_cnt",   {24'd0, cnt1},  32'd5);
        chk("t3_cnt2",  {30'd0, cnt2},  32'd3);
        tick();

        // Reset while bit position 3 of 0xFF is on the line
        load_valid = 1'b1;
        din        = 8'hFF;
        tick();
        load_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("t4_pre_sout", {31'd0, sout1}, 32'd1);
        reset = 1'b1;
        tick();
        chk("t4_sout",  {31'd0, sout1},  32'd0);
        chk("t4_busy",  {31'd0, busy1},  32'd0);
        chk("t4_ready", {31'd0, ready1}, 32'd1);
        chk("t4_cnt",   {24'd0, cnt1},   32'd0);
        chk("t4_done",  {31'd0, done1},  32'd0);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("t4_no_done", {31'd0, done1}, 32'd0);
            chk("t4_idle",    {31'd0, ready1}, 32'd1);
        end

        // Two words of 10010010: 2-bit counter saturates at 3
        run_word(8'b10010010, 8'b10010010, 8'b00001001);
        chk("t5_cnt2_a", {30'd0, cnt2}, 32'd2);
        tick();
        run_word(8'b10010010, 8'b10010010, 8'b00001001);
        chk("t5_cnt2_b", {30'd0, cnt2}, 32'd3);
        chk("t5_cnt1",   {24'd0, cnt1}, 32'd4);
        tick();

        // 10011001: matches at positions 0-3 and 4-7 only
        run_word(8'b10011001, 8'b10011001, 8'b00001000);
        chk("t6_done_em", {31'd0, em1},  32'd1);
        chk("t6_cnt1",    {24'd0, cnt1}, 32'd6);
        chk("t6_cnt2",    {30'd0, cnt2}, 32'd3);
        tick();
        tick();
        chk("t6_em_low", {31'd0, em1}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
